// File: rtl/clk_pkg.sv
// ============================================================================
// Module   : clk_pkg
// Brief    : Shared state encoding and default parameters for clk_ratio_meter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_pkg;

   localparam int unsigned c_default_div_ratio_width = 4;
   localparam int unsigned c_default_lock_count      = 3;
   localparam int unsigned c_default_sync_stages     = 2;

   localparam int unsigned c_state_width = 2;
   localparam logic [c_state_width-1:0] c_st_idle    = 2'd0;
   localparam logic [c_state_width-1:0] c_st_seek    = 2'd1;
   localparam logic [c_state_width-1:0] c_st_measure = 2'd2;

endpackage : clk_pkg

`default_nettype wire

// File: rtl/clk_sync.sv
// ============================================================================
// Module   : clk_sync
// Brief    : Multi-flop synchronizer for i_meas_clk with rising-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_sync
   import clk_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = c_default_sync_stages
) (
   input  logic i_ref_clk,
   input  logic i_rst_n,
   input  logic i_meas_clk,
   output logic o_synced,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_ref_clk) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_meas_clk};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_synced = r_sync[SYNC_STAGES-1];
   assign o_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : clk_sync

`default_nettype wire

// File: rtl/clk_ratio_meter.sv
// ============================================================================
// Module   : clk_ratio_meter
// Brief    : Measures period and high time of a divided clock in ref cycles,
//            with lock detection and no-edge timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_ratio_meter
   import clk_pkg::*;
#(
   parameter int unsigned DIV_RATIO_WIDTH = c_default_div_ratio_width,
   parameter int unsigned LOCK_COUNT      = c_default_lock_count,
   parameter int unsigned SYNC_STAGES     = c_default_sync_stages
) (
   input  logic                       i_ref_clk,
   input  logic                       i_rst_n,
   input  logic                       i_meas_en,
   input  logic                       i_meas_clk,
   output logic [DIV_RATIO_WIDTH-1:0] o_ratio,
   output logic [DIV_RATIO_WIDTH-1:0] o_high,
   output logic                       o_valid,
   output logic                       o_lock,
   output logic                       o_timeout
);

   localparam int unsigned c_match_width = $clog2(LOCK_COUNT + 1);
   localparam logic [DIV_RATIO_WIDTH-1:0] c_max_period = '1;
   localparam logic [DIV_RATIO_WIDTH-1:0] c_cnt_one    = DIV_RATIO_WIDTH'(1);
   localparam logic [c_match_width-1:0]   c_match_one  = c_match_width'(1);
   localparam logic [c_match_width-1:0]   c_lock_val   = c_match_width'(LOCK_COUNT);

   logic [c_state_width-1:0]   r_state;
   logic [c_state_width-1:0]   w_next_state;
   logic [DIV_RATIO_WIDTH-1:0] r_period;
   logic [DIV_RATIO_WIDTH-1:0] r_high_cnt;
   logic [c_match_width-1:0]   r_match;
   logic [c_match_width-1:0]   w_match_next;
   logic                       w_synced;
   logic                       w_rise;
   logic                       w_period_max;
   logic                       w_seek_start;
   logic                       w_capture;
   logic                       w_timeout_hit;
   logic                       w_count;

   clk_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_clk_sync (
      .i_ref_clk  (i_ref_clk),
      .i_rst_n    (i_rst_n),
      .i_meas_clk (i_meas_clk),
      .o_synced   (w_synced),
      .o_rise     (w_rise)
   );

   assign w_period_max = (r_period == c_max_period);

   always_ff @(posedge i_ref_clk) begin
      if (!i_rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (!i_meas_en) begin
         w_next_state = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle:    w_next_state = c_st_seek;
            c_st_seek:    if (w_rise) w_next_state = c_st_measure;
            c_st_measure: if (!w_rise && w_period_max) w_next_state = c_st_seek;
            default:      w_next_state = c_st_idle;
         endcase
      end
   end

   always_comb begin
      w_seek_start  = 1'b0;
      w_capture     = 1'b0;
      w_timeout_hit = 1'b0;
      w_count       = 1'b0;
      if (i_meas_en) begin
         case (r_state)
            c_st_seek: begin
               w_seek_start = w_rise;
            end
            c_st_measure: begin
               w_capture     = w_rise;
               w_timeout_hit = !w_rise && w_period_max;
               w_count       = !w_rise && !w_period_max;
            end
            default: begin
               w_count = 1'b0;
            end
         endcase
      end
   end

   // Run length of captures equal to the previously reported ratio, saturating.
   always_comb begin
      w_match_next = c_match_one;
      if (r_period == o_ratio) begin
         w_match_next = (r_match == c_lock_val) ? r_match : r_match + c_match_one;
      end
   end

   always_ff @(posedge i_ref_clk) begin
      if (!i_rst_n) begin
         r_period   <= '0;
         r_high_cnt <= '0;
         r_match    <= '0;
         o_ratio    <= '0;
         o_high     <= '0;
         o_valid    <= 1'b0;
         o_lock     <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (!i_meas_en) begin
            r_period   <= '0;
            r_high_cnt <= '0;
            r_match    <= '0;
            o_lock     <= 1'b0;
            o_timeout  <= 1'b0;
         end else if (w_seek_start) begin
            r_period   <= c_cnt_one;
            r_high_cnt <= c_cnt_one;
         end else if (w_capture) begin
            o_ratio    <= r_period;
            o_high     <= r_high_cnt;
            o_valid    <= 1'b1;
            o_timeout  <= 1'b0;
            r_match    <= w_match_next;
            o_lock     <= (w_match_next == c_lock_val);
            r_period   <= c_cnt_one;
            r_high_cnt <= c_cnt_one;
         end else if (w_timeout_hit) begin
            o_timeout  <= 1'b1;
            o_lock     <= 1'b0;
            o_ratio    <= '0;
            o_high     <= '0;
            r_match    <= '0;
            r_period   <= '0;
            r_high_cnt <= '0;
         end else if (w_count) begin
            r_period <= r_period + c_cnt_one;
            if (w_synced) begin
               r_high_cnt <= r_high_cnt + c_cnt_one;
            end
         end
      end
   end

endmodule : clk_ratio_meter

`default_nettype wire

// File: tb/tb_clk_ratio_meter.sv
// ============================================================================
// Module   : tb_clk_ratio_meter
// Brief    : Self-checking bench for clk_ratio_meter against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_ratio_meter;

   localparam int W    = 4;
   localparam int L    = 3;
   localparam int S    = 2;
   localparam int MAXP = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         mc = 1'b0;
   logic [W-1:0] o_ratio;
   logic [W-1:0] o_high;
   logic         o_valid;
   logic         o_lock;
   logic         o_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_ratio_meter #(
      .DIV_RATIO_WIDTH (W),
      .LOCK_COUNT      (L),
      .SYNC_STAGES     (S)
   ) dut (
      .i_ref_clk  (clk),
      .i_rst_n    (rst_n),
      .i_meas_en  (en),
      .i_meas_clk (mc),
      .o_ratio    (o_ratio),
      .o_high     (o_high),
      .o_valid    (o_valid),
      .o_lock     (o_lock),
      .o_timeout  (o_timeout)
   );

   // Reference model: edges found in the delayed sample history; period and
   // high time come from edge timestamps and the samples seen since the edge.
   bit           hist[$];
   bit           since_edge[$];
   int           caps[$];
   int           mode = 0;
   int           now = 0;
   int           t_edge = 0;
   logic [W-1:0] m_ratio = '0;
   logic [W-1:0] m_high = '0;
   bit           m_valid = 0;
   bit           m_lock = 0;
   bit           m_to = 0;

   function automatic bit caps_locked();
      if (caps.size() < L) return 1'b0;
      for (int i = 1; i < L; i++)
         if (caps[caps.size()-1-i] != caps[caps.size()-1]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int high_sum();
      int s = 0;
      foreach (since_edge[i]) s += since_edge[i];
      return s;
   endfunction

   task automatic model_step(input logic rn, input logic e, input logic m);
      bit syn, prv, edge_seen;
      now++;
      if (!rn) begin
         hist.delete();
         for (int i = 0; i <= S; i++) hist.push_back(1'b0);
         since_edge.delete();
         caps.delete();
         mode = 0;
         m_ratio = '0; m_high = '0; m_valid = 0; m_lock = 0; m_to = 0;
      end else begin
         syn = hist[S-1];
         prv = hist[S];
         edge_seen = syn && !prv;
         m_valid = 0;
         if (!e) begin
            mode = 0; m_lock = 0; m_to = 0;
            caps.delete();
         end else if (mode == 0) begin
            mode = 1;
         end else if (mode == 1) begin
            if (edge_seen) begin
               mode = 2; t_edge = now;
               since_edge.delete(); since_edge.push_back(syn);
            end
         end else begin
            if (edge_seen) begin
               m_ratio = W'(now - t_edge);
               m_high  = W'(high_sum());
               m_valid = 1; m_to = 0;
               caps.push_back(now - t_edge);
               if (caps.size() > L) void'(caps.pop_front());
               m_lock = caps_locked();
               t_edge = now;
               since_edge.delete(); since_edge.push_back(syn);
            end else if (now - t_edge == MAXP) begin
               m_to = 1; m_lock = 0; m_ratio = '0; m_high = '0;
               caps.delete();
               mode = 1;
            end else begin
               since_edge.push_back(syn);
            end
         end
         hist.push_front(m);
         void'(hist.pop_back());
      end
   endtask

   task automatic cyc(input logic rn, input logic e, input logic m);
      rst_n = rn; en = e; mc = m;
      model_step(rn, e, m);
      @(posedge clk);
      #1;
   endtask

   function automatic string got_str();
      return $sformatf("got r=%0d h=%0d v=%b l=%b t=%b", o_ratio, o_high, o_valid, o_lock, o_timeout);
   endfunction

   function automatic string want_str();
      return $sformatf("want r=%0d h=%0d v=%b l=%b t=%b", m_ratio, m_high, m_valid, m_lock, m_to);
   endfunction

   task automatic test_reset();
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      checks++; if (o_ratio !== '0) begin errors++; $display("FAIL reset_ratio got %0d want 0", o_ratio); end
      checks++; if (o_high !== '0) begin errors++; $display("FAIL reset_high got %0d want 0", o_high); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
      checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", o_lock); end
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", o_timeout); end
   endtask

   // Runs a fresh enable with a steady wave; checks every cycle, o_valid spacing
   // and that lock rises on the L-th valid.
   task automatic test_period(input string name, input int p, input int h, input int ncyc);
      int nvalid = 0, lock_at = 0, last_v = -1;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < ncyc; k++) begin
         cyc(1'b1, 1'b1, (k % p) < h);
         checks++;
         if ({o_ratio, o_high, o_valid, o_lock, o_timeout} !== {m_ratio, m_high, m_valid, m_lock, m_to}) begin
            errors++; $display("FAIL %s cycle %0d %s %s", name, k, got_str(), want_str());
         end
         if (o_valid === 1'b1) begin
            nvalid++;
            if (o_lock === 1'b1 && lock_at == 0) lock_at = nvalid;
            if (last_v >= 0) begin
               checks++;
               if (k - last_v != p) begin errors++; $display("FAIL %s_spacing got %0d want %0d", name, k - last_v, p); end
            end
            last_v = k;
            checks++;
            if (o_ratio !== W'(p) || o_high !== W'(h)) begin
               errors++; $display("FAIL %s_capture got r=%0d h=%0d want r=%0d h=%0d", name, o_ratio, o_high, p, h);
            end
         end
      end
      checks++;
      if (lock_at != L) begin errors++; $display("FAIL %s_lock_index got %0d want %0d", name, lock_at, L); end
   endtask

   task automatic test_switch();
      int caps6 = 0, lock_at = 0;
      for (int k = 0; k < 24; k++) cyc(1'b1, 1'b1, (k % 4) < 2);
      checks++;
      if (o_lock !== 1'b1) begin errors++; $display("FAIL switch_prelock got %b want 1", o_lock); end
      for (int k = 0; k < 42; k++) begin
         cyc(1'b1, 1'b1, (k % 6) < 3);
         checks++;
         if ({o_ratio, o_high, o_valid, o_lock, o_timeout} !== {m_ratio, m_high, m_valid, m_lock, m_to}) begin
            errors++; $display("FAIL switch cycle %0d %s %s", k, got_str(), want_str());
         end
         if (o_valid === 1'b1 && o_ratio === W'(6)) begin
            caps6++;
            if (caps6 == 1) begin
               checks++;
               if (o_lock !== 1'b0) begin errors++; $display("FAIL switch_unlock got %b want 0", o_lock); end
            end
            if (o_lock === 1'b1 && lock_at == 0) lock_at = caps6;
         end
      end
      checks++;
      if (lock_at != L) begin errors++; $display("FAIL switch_relock got %0d want %0d", lock_at, L); end
   endtask

   task automatic test_timeout();
      int k = 0, v_at = -1, to_at = -1;
      for (int j = 0; j < 24; j++) cyc(1'b1, 1'b1, (j % 4) < 2);
      // Final rising sample, then hold low; count edges after the sampling edge.
      cyc(1'b1, 1'b1, 1'b1);
      while (k < 40 && to_at < 0) begin
         cyc(1'b1, 1'b1, k == 0);
         k++;
         checks++;
         if ({o_ratio, o_high, o_valid, o_lock, o_timeout} !== {m_ratio, m_high, m_valid, m_lock, m_to}) begin
            errors++; $display("FAIL timeout cycle %0d %s %s", k, got_str(), want_str());
         end
         if (o_valid === 1'b1 && v_at < 0) v_at = k;
         if (o_timeout === 1'b1) to_at = k;
      end
      checks++;
      if (v_at != S) begin errors++; $display("FAIL valid_latency got %0d want %0d", v_at, S); end
      checks++;
      if (to_at != S + MAXP) begin errors++; $display("FAIL timeout_delay got %0d want %0d", to_at, S + MAXP); end
      checks++;
      if (o_ratio !== '0 || o_lock !== 1'b0) begin
         errors++; $display("FAIL timeout_outputs got r=%0d l=%b want r=0 l=0", o_ratio, o_lock);
      end
      v_at = -1;
      for (int j = 0; j < 16; j++) begin
         cyc(1'b1, 1'b1, (j % 4) < 2);
         if (o_valid === 1'b1 && v_at < 0) begin
            v_at = j;
            checks++;
            if (o_timeout !== 1'b0 || o_ratio !== W'(4)) begin
               errors++; $display("FAIL timeout_clear got t=%b r=%0d want t=0 r=4", o_timeout, o_ratio);
            end
         end else if (v_at < 0) begin
            checks++;
            if (o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold got %b want 1", o_timeout); end
         end
      end
      checks++;
      if (v_at < 0) begin errors++; $display("FAIL timeout_restart got no valid want valid"); end
   endtask

   task automatic test_reset_mid();
      int first_v = -1;
      for (int j = 0; j < 24; j++) cyc(1'b1, 1'b1, (j % 4) < 2);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      checks++;
      if ({o_ratio, o_high, o_valid, o_lock, o_timeout} !== '0) begin
         errors++; $display("FAIL reset_mid_outputs %s want all 0", got_str());
      end
      for (int j = 0; j < 20; j++) begin
         cyc(1'b1, 1'b1, ((j + 2) % 4) < 2);
         checks++;
         if ({o_ratio, o_high, o_valid, o_lock, o_timeout} !== {m_ratio, m_high, m_valid, m_lock, m_to}) begin
            errors++; $display("FAIL reset_mid cycle %0d %s %s", j, got_str(), want_str());
         end
         if (o_valid === 1'b1 && first_v < 0) first_v = j;
      end
      // Needs IDLE->SEEK, a synced edge, then one full period before a capture.
      checks++;
      if (first_v < 4 + S) begin errors++; $display("FAIL reset_mid_first_valid got %0d want >= %0d", first_v, 4 + S); end
   endtask

   task automatic test_const_high();
      int nvalid = 0;
      cyc(1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 40; j++) begin
         cyc(1'b1, 1'b1, 1'b1);
         checks++;
         if ({o_ratio, o_high, o_valid, o_lock, o_timeout} !== {m_ratio, m_high, m_valid, m_lock, m_to}) begin
            errors++; $display("FAIL const_high cycle %0d %s %s", j, got_str(), want_str());
         end
         if (o_valid === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 0 || o_timeout !== 1'b1) begin
         errors++; $display("FAIL const_high_summary got valids=%0d t=%b want valids=0 t=1", nvalid, o_timeout);
      end
   endtask

   task automatic test_random();
      int n = 0;
      int kind, p, h, reps, len;
      bit e, r, m;
      while (n < 2000) begin
         kind = $urandom_range(0, 11);
         p = $urandom_range(2, 15);
         h = $urandom_range(1, p - 1);
         reps = $urandom_range(1, 5);
         len = (kind == 0) ? $urandom_range(1, 3) : (kind == 1) ? $urandom_range(10, 20) : (kind == 2) ? 1 : p * reps;
         for (int j = 0; j < len; j++) begin
            r = (kind != 2);
            e = (kind != 0);
            m = (kind >= 3) ? ((j % p) < h) : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc(r, e, m);
            n++;
            checks++;
            if ({o_ratio, o_high, o_valid, o_lock, o_timeout} !== {m_ratio, m_high, m_valid, m_lock, m_to}) begin
               errors++; $display("FAIL random cycle %0d %s %s", n, got_str(), want_str());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_period("p4", 4, 2, 40);
      test_period("p5", 5, 2, 40);
      test_switch();
      test_timeout();
      test_reset_mid();
      test_const_high();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_clk_ratio_meter

`default_nettype wire

// File: doc/clk_ratio_meter.md
CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 Parameter DIV_RATIO_WIDTH, default 4: width of measured ratio; max measurable period 2^DIV_RATIO_WIDTH-1 ref cycles.
REQ-002 Parameter LOCK_COUNT, default 3: consecutive equal periods required for lock.
REQ-003 Parameter SYNC_STAGES, default 2: flops in input synchronizer, minimum 2.
REQ-004 i_ref_clk  in  1  reference clock; sole clock, all flops rising-edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_meas_en  in  1  measurement enable; low forces IDLE.
REQ-007 i_meas_clk  in  1  divided clock under test, sampled as data.
REQ-008 o_ratio  out  DIV_RATIO_WIDTH  last measured period in ref cycles.
REQ-009 o_high  out  DIV_RATIO_WIDTH  ref cycles i_meas_clk was high in that period.
REQ-010 o_valid  out  1  one-cycle pulse when o_ratio/o_high update.
REQ-011 o_lock  out  1  level; LOCK_COUNT consecutive identical o_ratio values seen.
REQ-012 o_timeout  out  1  level; no rising edge within max period.

Function
REQ-013 i_meas_clk shall pass through SYNC_STAGES flops; rising edge = synced high and previous synced value low.
REQ-014 States: IDLE, SEEK, MEASURE; IDLE when i_meas_en=0; IDLE->SEEK when i_meas_en=1.
REQ-015 SEEK: on first detected edge, period counter:=1, high counter:=1, go MEASURE; no o_valid.
REQ-016 MEASURE: each non-edge cycle period counter +1; high counter +1 when synced value is high.
REQ-017 MEASURE edge cycle: o_ratio:=period counter, o_high:=high counter, o_valid=1 next cycle, counters reload to 1.
REQ-018 Edges N ref cycles apart shall yield o_ratio=N exactly; o_valid latency from input sample of the edge = SYNC_STAGES+1 cycles.
REQ-019 Match counter: captured period equal to previous o_ratio -> increment, saturating at LOCK_COUNT; unequal -> 1.
REQ-020 o_lock=1 the cycle o_valid shows match counter reaching LOCK_COUNT; o_lock=0 on first mismatching capture (same cycle as its o_valid).
REQ-021 Period counter equal to 2^DIV_RATIO_WIDTH-1 with no edge: next cycle o_timeout=1, o_lock=0, o_ratio=0, o_high=0, match=0, state SEEK, no o_valid.
REQ-022 o_timeout cleared on next o_valid.
REQ-023 i_meas_en falling: next cycle IDLE, o_lock=0, o_valid=0, o_timeout=0, counters 0; o_ratio/o_high hold.
REQ-024 Constant input (ratio 1 bypass, stopped clock) shall report only via o_timeout, never o_valid.
REQ-025 Counters shall not wrap; all arithmetic DIV_RATIO_WIDTH bits unsigned.

Reset
REQ-026 i_rst_n=0 at a rising i_ref_clk: state IDLE, sync flops 0, all counters 0, o_ratio=0, o_high=0, o_valid=0, o_lock=0, o_timeout=0.
REQ-027 Reset mid-measurement shall discard partial counts; first o_valid after release needs a fresh SEEK edge.

Structure
REQ-028 State encoding and default parameter constants in shared package clk_pkg.
REQ-029 Sub-module clk_sync (SYNC_STAGES-deep synchronizer with edge-detect output); remainder in clk_ratio_meter.

Verification
REQ-030 Enable, input period 4 (high 2, low 2) -> o_ratio=4, o_high=2 each o_valid; o_lock=1 on 3rd o_valid.
REQ-031 Period 5 (high 2, low 3) -> o_ratio=5, o_high=2; o_valid spacing 5 cycles; lock after 3 matches.
REQ-032 Locked at 4, switch to 6 (high 3) -> first 6-capture o_lock=0, o_ratio=6; relock after 3 consecutive 6s.
REQ-033 Locked at 4, hold input low -> o_timeout=1 exactly 15 cycles after last edge counter reload, o_ratio=0; restart period 4 -> o_timeout=0 on next o_valid.
REQ-034 Assert i_rst_n=0 one cycle mid-period while locked -> all outputs 0 next cycle; no o_valid before one SEEK edge plus one full period.
REQ-035 Input tied to ref-clock-rate toggle pattern impossible at sampling (constant 1) -> o_timeout=1, o_valid never asserted.
